instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The parameter list SHALL be: IMEM_DEPTH, default 64, instruction memory size in 32-bit words (power of two).
REQ-002 The parameter list SHALL be: RESET_PC, default 64'h0, PC value loaded on reset.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  synchronous reset, active high.
REQ-006 Port: redirect_valid  input  1  taken-branch redirect request from the decode/execute side.
REQ-007 Port: redirect_pc  input  64  redirect target address.
REQ-008 Port: out_ready  input  1  decode stage accepts out_inst/out_pc this cycle.
REQ-009 Port: out_valid  output  1  out_inst/out_pc hold a valid fetched instruction.
REQ-010 Port: out_inst  output  32  fetched instruction, feeds decode inst.
REQ-011 Port: out_pc  output  64  byte address of out_inst.
REQ-012 Port: halted  output  1  fetch is stopped (HALT state).
REQ-013 Port: fault  output  1  sticky flag for a misaligned or out-of-range PC.
REQ-014 Port: inst_count  output  32  count of instructions handed to decode.
REQ-015 Port: imem_wr_en  input  1  program-load write strobe.
REQ-016 Port: imem_wr_addr  input  clog2(IMEM_DEPTH)  word address for the program-load write.
REQ-017 Port: imem_wr_data  input  32  program-load data.

Function
REQ-018 The state machine SHALL have two states, FETCH and HALT, held in the state register; halted SHALL be 1 exactly when the state is HALT.
REQ-019 The PC register SHALL index memory word pc[clog2(IMEM_DEPTH)+1:2]; memory read SHALL be combinational, with output registered (1-cycle fetch latency).
REQ-020 Load condition: state is FETCH and (out_valid=0 or out_ready=1) and redirect_valid=0. On a load:
- out_inst is set to imem[pc], out_pc to pc, out_valid to 1.
- pc advances by 4.
REQ-021 Backpressure: with out_valid=1 and out_ready=0, out_inst, out_pc, out_valid and pc SHALL hold unchanged.
REQ-022 Handshake: a transfer SHALL occur when out_valid=1, out_ready=1 and redirect_valid=0; each transfer increments inst_count by 1, wrapping from 32'hFFFFFFFF to 0.
REQ-023 Redirect: redirect_valid=1 SHALL take priority over everything except reset, in either state. It SHALL:
- set pc to redirect_pc;
- clear out_valid, squashing the held instruction with no transfer counted;
- move the state to FETCH.
The target instruction SHALL appear with out_valid=1 one edge later.
REQ-024 Misaligned redirect: if redirect_pc[1:0]≠0, the block SHALL instead set fault=1, enter HALT, clear out_valid, and leave pc unchanged.
REQ-025 End of program: if a load would read the word 32'h00000000, no load SHALL occur and the state SHALL become HALT.
- The held instruction stays valid until transferred, then out_valid goes to 0.
- pc stays at the zero word's address.
REQ-026 Out of range: if pc ≥ 4*IMEM_DEPTH in FETCH, the block SHALL enter HALT with fault=1 and no wrap-around; the pending out instruction still drains as in REQ-025.
REQ-027 In HALT, no loads SHALL occur; only redirect (REQ-023) or reset leaves HALT.
REQ-028 fault SHALL be sticky and cleared only by reset.
REQ-029 When imem_wr_en=1, imem[imem_wr_addr] SHALL be written at the edge. A load from the same word in the same cycle SHALL capture the old data.

Reset
REQ-030 Reset SHALL be synchronous and active high, with priority over all other inputs.
REQ-031 Reset SHALL set: pc=RESET_PC, state=FETCH, out_valid=0, out_inst=32'h0, out_pc=64'h0, fault=0, inst_count=0.
REQ-032 Reset SHALL NOT clear the instruction memory contents; the first load occurs on the first edge after reset deasserts.
REQ-033 Reset asserted mid-redirect or mid-backpressure SHALL discard all in-flight state.

Structure
REQ-034 The shared package/header SHALL hold: the instruction width (32), XLEN (64), the HALT encoding 32'h0, the opcode constants used by decode, and the FETCH/HALT state encodings.
REQ-035 The memory array and write port SHALL be one sub-module, instruction_memory; the PC, FSM, output register and counter SHALL live in instruction_fetch.

Verification
REQ-036 Sequential fetch: load words 0..3 with 0x00A00093, 0x00208133, 0x0000B183, 0x0; reset; out_ready=1.
- Required: out_pc 0, 4, 8 on consecutive edges.
- Then halted=1, fault=0, inst_count=3.
REQ-037 Backpressure: drop out_ready for 3 cycles while out_pc=4; out_inst/out_pc hold, pc does not advance, inst_count is unchanged; on release out_pc=8 follows.
REQ-038 Redirect: assert redirect_valid with redirect_pc=0x10 while out_pc=8 and out_ready=1.
- Edge 1: out_valid=0, no count.
- Edge 2: out_pc=0x10.
REQ-039 Misaligned redirect: redirect_pc=0x6 -> fault=1, halted=1, out_valid=0; a later redirect to 0x0 resumes fetch with fault still 1.
REQ-040 Out of range: IMEM_DEPTH=4 with no zero word -> after out_pc=0xC, halted=1 and fault=1, with no wrap to 0.
REQ-041 Reset mid-stall: with out_valid=1 and out_ready=0, assert reset -> all outputs at reset values on the next edge, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch definitions: datapath widths, the end-of-program word,
// decode opcode constants, the fetch FSM encoding and the fetch payload.
package instruction_fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned XLEN   = 64;

    // A fetched word equal to this value marks the end of the program.
    localparam logic [INST_W-1:0] HALT_INST = 32'h0000_0000;

    // Major opcodes consumed by the decode stage.
    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_LUI    = 7'b011_0111;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_e;

    // Instruction word plus the byte address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_pkt_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch <-> decode bus: branch redirect request (decode -> fetch) and the
// valid/ready instruction hand-off (fetch -> decode).
//   master : fetch side   (drives out_*, receives redirect and out_ready)
//   slave  : decode side  (drives redirect and out_ready, receives out_*)
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              out_ready;
    logic              out_valid;
    logic [INST_W-1:0] out_inst;
    logic [XLEN-1:0]   out_pc;

    modport master (
        input  redirect_valid, redirect_pc, out_ready,
        output out_valid, out_inst, out_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, out_ready,
        input  out_valid, out_inst, out_pc
    );
endinterface

// File: rtl/instruction_fetch_memory.sv
// instruction_memory: word-addressed instruction store.
//   clk        : write clock
//   wr_en_i    : program-load write strobe
//   wr_addr_i  : word address of the write
//   wr_data_i  : word to write
//   rd_addr_i  : word address of the combinational read
//   rd_data_c  : combinational read data (pre-write contents on a collision)
// Contents are deliberately not reset so a program survives a core reset.
module instruction_memory
    import instruction_fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [INST_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [INST_W-1:0] rd_data_c
);

    logic [INST_W-1:0] mem_q [DEPTH];

    // Program-load write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_c = mem_q[rd_addr_i];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, FETCH/HALT control, registered fetch output and
// hand-off counter in front of a combinational-read instruction memory.
//   clk, reset           : clock, synchronous active-high reset
//   fe (master)          : redirect in, out_valid/out_inst/out_pc to decode
//   halted               : state is HALT
//   fault                : sticky misaligned / out-of-range PC flag
//   inst_count           : instructions handed to decode (wrapping)
//   imem_wr_en/addr/data : program-load write port
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter  int unsigned     IMEM_DEPTH = 64,
    parameter  logic [XLEN-1:0] RESET_PC   = 64'h0,
    localparam int unsigned     AW         = $clog2(IMEM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    instruction_fetch_if.master  fe,
    output logic                 halted,
    output logic                 fault,
    output logic [31:0]          inst_count,
    input  logic                 imem_wr_en,
    input  logic [AW-1:0]        imem_wr_addr,
    input  logic [INST_W-1:0]    imem_wr_data
);

    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(4 * IMEM_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    fetch_pkt_t        out_q, out_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic [31:0]       count_q, count_d;

    logic [INST_W-1:0] rd_word;
    logic              xfer;
    logic              can_load;
    logic              pc_bad;

    instruction_memory #(
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clk       (clk),
        .wr_en_i   (imem_wr_en),
        .wr_addr_i (imem_wr_addr),
        .wr_data_i (imem_wr_data),
        .rd_addr_i (pc_q[AW+1:2]),
        .rd_data_c (rd_word)
    );

    // Next-state logic: redirect beats everything; otherwise drain/load.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        out_d    = out_q;
        valid_d  = valid_q;
        fault_d  = fault_q;
        count_d  = count_q;

        xfer     = valid_q & fe.out_ready & ~fe.redirect_valid;
        can_load = ~valid_q | fe.out_ready;
        pc_bad   = (pc_q >= PC_LIMIT) | (pc_q[1:0] != 2'b00);

        // A completed hand-off empties the output slot unless a load refills it.
        if (xfer) begin
            count_d = count_q + 32'd1;
            valid_d = 1'b0;
        end

        if (fe.redirect_valid) begin
            valid_d = 1'b0;
            if (fe.redirect_pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
                state_d = ST_HALT;
            end else begin
                pc_d    = fe.redirect_pc;
                state_d = ST_FETCH;
            end
        end else if (state_q == ST_FETCH) begin
            if (pc_bad) begin
                fault_d = 1'b1;
                state_d = ST_HALT;
            end else if (can_load) begin
                // The zero word stops fetch; pc stays parked on it.
                if (rd_word == HALT_INST) begin
                    state_d = ST_HALT;
                end else begin
                    out_d.inst = rd_word;
                    out_d.pc   = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + 64'd4;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    assign fe.out_valid = valid_q;
    assign fe.out_inst  = out_q.inst;
    assign fe.out_pc    = out_q.pc;
    assign halted       = (state_q == ST_HALT);
    assign fault        = fault_q;
    assign inst_count   = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a behavioural model.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Main DUT (64 words).
    logic        reset;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        halted, fault;
    logic [31:0] count;
    instruction_fetch_if bus ();

    instruction_fetch #(.IMEM_DEPTH(64), .RESET_PC(64'h0)) dut (
        .clk          (clk),
        .reset        (reset),
        .fe           (bus.master),
        .halted       (halted),
        .fault        (fault),
        .inst_count   (count),
        .imem_wr_en   (wr_en),
        .imem_wr_addr (wr_addr),
        .imem_wr_data (wr_data)
    );

    // Small DUT (4 words) for the out-of-range case.
    logic        reset4;
    logic        wr_en4;
    logic [1:0]  wr_addr4;
    logic [31:0] wr_data4;
    logic        halted4, fault4;
    logic [31:0] count4;
    instruction_fetch_if bus4 ();

    instruction_fetch #(.IMEM_DEPTH(4), .RESET_PC(64'h0)) dut4 (
        .clk          (clk),
        .reset        (reset4),
        .fe           (bus4.master),
        .halted       (halted4),
        .fault        (fault4),
        .inst_count   (count4),
        .imem_wr_en   (wr_en4),
        .imem_wr_addr (wr_addr4),
        .imem_wr_data (wr_data4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model of the main DUT ----------------
    logic [31:0] m_mem [64];
    logic [63:0] m_pc, m_opc;
    logic [31:0] m_inst, m_count;
    bit          m_valid, m_halted, m_fault;
    bit          model_ready = 1'b0;

    task automatic model_step();
        bit          xfer, slot_free;
        logic [31:0] w;
        if (reset) begin
            m_pc = 64'h0; m_opc = 64'h0; m_inst = 32'h0; m_count = 32'h0;
            m_valid = 0; m_halted = 0; m_fault = 0;
            model_ready = 1'b1;
        end else if (bus.redirect_valid) begin
            m_valid = 0;
            if (bus.redirect_pc % 4 != 0) begin
                m_fault = 1; m_halted = 1;
            end else begin
                m_pc = bus.redirect_pc; m_halted = 0;
            end
        end else begin
            xfer      = m_valid && bus.out_ready;
            slot_free = !m_valid || bus.out_ready;
            if (xfer) m_count = m_count + 1;
            if (m_halted) begin
                if (xfer) m_valid = 0;
            end else if (m_pc >= 64 * 4 || m_pc % 4 != 0) begin
                m_halted = 1; m_fault = 1;
                if (xfer) m_valid = 0;
            end else if (slot_free) begin
                w = m_mem[m_pc / 4];
                if (w == 32'h0) begin
                    m_halted = 1;
                    if (xfer) m_valid = 0;
                end else begin
                    m_inst = w; m_opc = m_pc; m_valid = 1; m_pc = m_pc + 4;
                end
            end
        end
        // Memory is written after the read so a same-cycle load sees old data.
        if (wr_en) m_mem[wr_addr] = wr_data;
    endtask

    // Advance the model on each edge, then compare the DUT to it.
    always @(posedge clk) begin
        model_step();
        #1;
        if (model_ready) begin
            chk("out_valid",  64'(bus.out_valid), 64'(m_valid));
            chk("halted",     64'(halted),        64'(m_halted));
            chk("fault",      64'(fault),         64'(m_fault));
            chk("inst_count", 64'(count),         64'(m_count));
            chk("out_inst",   64'(bus.out_inst),  64'(m_inst));
            chk("out_pc",     bus.out_pc,         m_opc);
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] prog_word(input int i);
        case (i)
            0: return 32'h00A0_0093;
            1: return 32'h0020_8133;
            2: return 32'h0000_B183;
            3: return 32'h0000_0000;
            default: return $urandom | 32'h1;
        endcase
    endfunction

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
        reset4 = 1'b1; wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = '0;
        bus4.redirect_valid = 1'b0; bus4.redirect_pc = '0; bus4.out_ready = 1'b0;
        step();

        // Program both memories while held in reset.
        for (int i = 0; i < 64; i++) begin
            wr_en = 1'b1; wr_addr = 6'(i); wr_data = prog_word(i);
            wr_en4 = (i < 4); wr_addr4 = 2'(i); wr_data4 = 32'h1000_0013 + 32'(i);
            step();
        end
        wr_en = 1'b0; wr_en4 = 1'b0;
        chk("reset_valid",  64'(bus.out_valid), 64'h0);
        chk("reset_halted", 64'(halted),        64'h0);

        // Out of range on the 4-word instance: no wrap past 0xC.
        reset4 = 1'b0; bus4.out_ready = 1'b1;
        step(); chk("oor_pc0", bus4.out_pc, 64'h0);
        step(); chk("oor_pc4", bus4.out_pc, 64'h4);
        step(); chk("oor_pc8", bus4.out_pc, 64'h8);
        step(); chk("oor_pcC", bus4.out_pc, 64'hC);
        step();
        chk("oor_halted", 64'(halted4),        64'h1);
        chk("oor_fault",  64'(fault4),         64'h1);
        chk("oor_valid",  64'(bus4.out_valid), 64'h0);
        chk("oor_count",  64'(count4),         64'd4);
        step();
        chk("oor_nowrap", bus4.out_pc,         64'hC);
        chk("oor_stay",   64'(halted4),        64'h1);

        // Sequential fetch to the zero word.
        reset = 1'b0; bus.out_ready = 1'b1;
        step(); chk("seq_pc0", bus.out_pc, 64'h0); chk("seq_inst0", 64'(bus.out_inst), 64'h00A00093);
        step(); chk("seq_pc4", bus.out_pc, 64'h4);
        step(); chk("seq_pc8", bus.out_pc, 64'h8);
        step();
        chk("seq_halted", 64'(halted), 64'h1);
        chk("seq_fault",  64'(fault),  64'h0);
        chk("seq_count",  64'(count),  64'd3);
        chk("seq_valid",  64'(bus.out_valid), 64'h0);

        // Backpressure while out_pc=4.
        reset = 1'b1; step();
        reset = 1'b0; step(); step();
        chk("bp_pc4", bus.out_pc, 64'h4);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_pc",    bus.out_pc,          64'h4);
            chk("bp_hold_inst",  64'(bus.out_inst),   64'h00208133);
            chk("bp_hold_count", 64'(count),          64'd1);
        end
        bus.out_ready = 1'b1;
        step(); chk("bp_release_pc", bus.out_pc, 64'h8); chk("bp_release_cnt", 64'(count), 64'd2);

        // Redirect while out_pc=8.
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h10;
        step(); chk("rd_squash", 64'(bus.out_valid), 64'h0); chk("rd_nocount", 64'(count), 64'd2);
        bus.redirect_valid = 1'b0;
        step(); chk("rd_target", bus.out_pc, 64'h10); chk("rd_valid", 64'(bus.out_valid), 64'h1);

        // Misaligned redirect, then recovery with fault kept.
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h6;
        step();
        chk("mis_fault",  64'(fault),         64'h1);
        chk("mis_halted", 64'(halted),        64'h1);
        chk("mis_valid",  64'(bus.out_valid), 64'h0);
        bus.redirect_pc = 64'h0;
        step(); chk("mis_resume", 64'(halted), 64'h0);
        bus.redirect_valid = 1'b0;
        step(); chk("mis_pc0", bus.out_pc, 64'h0); chk("mis_sticky", 64'(fault), 64'h1);

        // Reset during a stall.
        bus.out_ready = 1'b0;
        step(); step(); chk("rst_stall_valid", 64'(bus.out_valid), 64'h1);
        reset = 1'b1;
        step();
        chk("rst_valid", 64'(bus.out_valid), 64'h0);
        chk("rst_pc",    bus.out_pc,         64'h0);
        chk("rst_inst",  64'(bus.out_inst),  64'h0);
        chk("rst_count", 64'(count),         64'h0);
        chk("rst_fault", 64'(fault),         64'h0);
        reset = 1'b0; bus.out_ready = 1'b1;
        step(); chk("rst_restart", bus.out_pc, 64'h0); chk("rst_inst0", 64'(bus.out_inst), 64'h00A00093);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            reset              = ($urandom_range(0, 199) == 0);
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.redirect_valid = ($urandom_range(0, 15) == 0);
            bus.redirect_pc    = 64'($urandom_range(0, 80)) * 64'd4;
            if ($urandom_range(0, 9) == 0) bus.redirect_pc = bus.redirect_pc + 64'($urandom_range(1, 3));
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_addr = 6'($urandom);
            wr_data = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom | 32'h1);
            step();
        end
        reset = 1'b0; bus.redirect_valid = 1'b0; wr_en = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
